data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 22 ++
 rtl/data_mem_responder_array.sv | 30 +++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 tb/tb_data_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: word type, FSM states and
// the request classification latched at accept.
package Common;

  typedef logic [31:0] uint32_t;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request kind captured at accept; BAD is read and write raised together.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    BAD  = 2'd3
  } mem_op_t;

endpackage

// File: rtl/data_mem_responder_array.sv
// Word storage with per-byte-lane write enables and a combinational read port.
// Contents are deliberately not reset.
module data_mem_array
  import Common::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  uint32_t       i_wdata,
  output uint32_t       o_rdata
);

  uint32_t r_mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  // Asynchronous read of the addressed word.
  always_comb begin
    o_rdata = r_mem[i_addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder. A request is accepted in IDLE when
// read or write is high, then the FSM waits WAIT_STATES cycles and presents a
// one-cycle response. Handshake: ready is high only in IDLE; a request is
// taken on any rising edge where (read|write) && ready && !rst; requests seen
// while not ready are dropped, not queued. resp_valid qualifies error and the
// response value of dataMemOut for exactly one cycle.
module data_mem_responder
  import Common::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] adress_mem,
  input  logic [3:0]  maskByte,
  input  logic        read,
  input  logic        write,
  input  uint32_t     dataMemIn,
  output logic        ready,
  output uint32_t     dataMemOut,
  output logic        resp_valid,
  output logic        error,
  output state_t      o_dbg_state
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] DEPTH_L   = 31'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t      AFTER_ACC = (WAIT_STATES > 0) ? WAIT : RESP;

  state_t      r_state;
  logic [3:0]  r_cnt;
  mem_op_t     r_op;
  logic [29:0] r_addr;
  logic [3:0]  r_mask;
  uint32_t     r_data;
  uint32_t     r_dout;

  logic        w_accept;
  mem_op_t     w_op_in;
  logic        w_in_range;
  logic        w_rd_resp;
  uint32_t     w_rd_data;
  uint32_t     w_mem_rdata;
  logic [3:0]  w_we;

  // Classify the incoming request.
  always_comb begin
    w_op_in = NONE;
    if (read && write) w_op_in = BAD;
    else if (read)     w_op_in = RD;
    else if (write)    w_op_in = WR;
  end

  // Response decode: range check, read data selection and write lane enables.
  always_comb begin
    w_accept   = (r_state == IDLE) && (read || write);
    w_in_range = ({1'b0, r_addr} < DEPTH_L);
    w_rd_resp  = (r_state == RESP) && ((r_op == RD) || (r_op == BAD));
    w_rd_data  = ((r_op == RD) && w_in_range) ? w_mem_rdata : '0;
    w_we       = ((r_state == RESP) && (r_op == WR) && w_in_range && !rst) ? r_mask : 4'b0000;
  end

  // Output drive; a reset in the RESP cycle suppresses the strobe.
  always_comb begin
    ready       = (r_state == IDLE);
    resp_valid  = (r_state == RESP) && !rst;
    error       = resp_valid && ((r_op == BAD) || !w_in_range);
    dataMemOut  = w_rd_resp ? w_rd_data : r_dout;
    o_dbg_state = r_state;
  end

  // Request payload latches, loaded at accept.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_addr <= adress_mem;
      r_mask <= maskByte;
      r_data <= dataMemIn;
    end
  end

  // Control FSM, wait counter and held read value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_op    <= NONE;
      r_dout  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_op_in;
            r_cnt   <= WAIT_LOAD;
            r_state <= AFTER_ACC;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          if (w_rd_resp) r_dout <= w_rd_data;
          r_op    <= NONE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata (r_data),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) driven by
// directed requests, a transaction-level model checked every cycle, and
// hand-computed literal checks of latency and data.
module tb_data_mem_responder;
  import Common::*;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [29:0] addr  [2];
  logic [3:0]  mask  [2];
  logic [31:0] wdata [2];
  logic        rdy   [2];
  logic        rv    [2];
  logic        err   [2];
  logic [31:0] dout  [2];
  state_t      dbg   [2];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_w2 (
    .clk(clk), .rst(rst[0]), .adress_mem(addr[0]), .maskByte(mask[0]),
    .read(rd[0]), .write(wr[0]), .dataMemIn(wdata[0]), .ready(rdy[0]),
    .dataMemOut(dout[0]), .resp_valid(rv[0]), .error(err[0]), .o_dbg_state(dbg[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .rst(rst[1]), .adress_mem(addr[1]), .maskByte(mask[1]),
    .read(rd[1]), .write(wr[1]), .dataMemIn(wdata[1]), .ready(rdy[1]),
    .dataMemOut(dout[1]), .resp_valid(rv[1]), .error(err[1]), .o_dbg_state(dbg[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One request in flight at most: the model remembers when the response is
  // due and when the next accept becomes legal, and keeps its own memory.
  bit          model_on = 1'b0;
  logic [31:0] mm       [2][DEPTH];
  int          next_acc [2];
  int          resp_at  [2];
  bit          pend     [2];
  logic        p_rd     [2];
  logic        p_wr     [2];
  logic [29:0] p_addr   [2];
  logic [3:0]  p_mask   [2];
  logic [31:0] p_data   [2];
  logic [31:0] exp_dout [2];

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        bit          e_rdy;
        bit          e_rv;
        bit          bad;
        bit          oor;
        logic [31:0] e_out;
        e_rdy = (cyc >= next_acc[k]);
        e_rv  = pend[k] && (cyc == resp_at[k]) && !rst[k];
        bad   = p_rd[k] && p_wr[k];
        oor   = (p_addr[k] >= 30'(DEPTH));
        e_out = exp_dout[k];
        if (e_rv && p_rd[k]) begin
          if (bad || oor) e_out = 32'h0;
          else            e_out = mm[k][p_addr[k][9:0]];
        end
        check($sformatf("dut%0d ready", k), {31'b0, rdy[k]}, {31'b0, e_rdy});
        check($sformatf("dut%0d resp_valid", k), {31'b0, rv[k]}, {31'b0, e_rv});
        check($sformatf("dut%0d dataMemOut", k), dout[k], e_out);
        if (e_rv) check($sformatf("dut%0d error", k), {31'b0, err[k]}, {31'b0, bad || oor});

        if (rst[k]) begin
          pend[k]     = 1'b0;
          next_acc[k] = cyc + 1;
          exp_dout[k] = 32'h0;
        end else begin
          if (e_rv) begin
            if (p_rd[k]) exp_dout[k] = e_out;
            else if (!oor) begin
              for (int i = 0; i < 4; i++)
                if (p_mask[k][i]) mm[k][p_addr[k][9:0]][8*i +: 8] = p_data[k][8*i +: 8];
            end
            pend[k] = 1'b0;
          end
          if (e_rdy && (rd[k] || wr[k])) begin
            pend[k]     = 1'b1;
            p_rd[k]     = rd[k];
            p_wr[k]     = wr[k];
            p_addr[k]   = addr[k];
            p_mask[k]   = mask[k];
            p_data[k]   = wdata[k];
            resp_at[k]  = cyc + 1 + ws(k);
            next_acc[k] = cyc + 2 + ws(k);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge ending RESP.
  task automatic req(input int k, input logic r, input logic w, input logic [29:0] a,
                     input logic [3:0] m, input logic [31:0] d,
                     output int lat, output logic [31:0] o, output logic e);
    int acc_c;
    rd[k] = r; wr[k] = w; addr[k] = a; mask[k] = m; wdata[k] = d;
    acc_c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy[k]) begin acc_c = cyc; break; end
    end
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
    lat = -1; o = '0; e = 1'b0;
    if (acc_c >= 0) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (rv[k]) begin lat = cyc - acc_c; o = dout[k]; e = err[k]; break; end
      end
    end
    if (acc_c < 0 || lat < 0) begin
      checks++; errors++;
      $display("FAIL dut%0d handshake timeout", k);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] o;
    logic        e;
    logic [5:0]  rv_pat;
    logic [5:0]  rdy_pat;
    int          rv_cnt;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; mask[k] = '0; wdata[k] = '0;
      next_acc[k] = 0; resp_at[k] = 0; pend[k] = 1'b0; exp_dout[k] = 32'h0;
      p_rd[k] = 1'b0; p_wr[k] = 1'b0; p_addr[k] = '0; p_mask[k] = '0; p_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    model_on = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("reset ready", {31'b0, rdy[0]}, 32'd1);
    check("reset resp_valid", {31'b0, rv[0]}, 32'd0);
    check("reset dataMemOut", dout[0], 32'h0);
    check("reset state", 32'(dbg[0]), 32'(IDLE));
    @(posedge clk); #1;

    // Full write then read back, 2 wait states.
    req(0, 1'b0, 1'b1, 30'd5, 4'b1111, 32'hDEADBEEF, lat, o, e);
    check("w5 latency", 32'(lat), 32'd3);
    check("w5 error", {31'b0, e}, 32'd0);
    req(0, 1'b1, 1'b0, 30'd5, 4'b0000, 32'h0, lat, o, e);
    check("r5 latency", 32'(lat), 32'd3);
    check("r5 data", o, 32'hDEADBEEF);

    // Partial lane writes.
    req(0, 1'b0, 1'b1, 30'd5, 4'b0001, 32'h000000AA, lat, o, e);
    req(0, 1'b0, 1'b1, 30'd5, 4'b0010, 32'h0000BB00, lat, o, e);
    req(0, 1'b1, 1'b0, 30'd5, 4'b1010, 32'h0, lat, o, e);
    check("lanes data", o, 32'hDEADBBAA);

    // Out-of-range accesses.
    req(0, 1'b0, 1'b1, 30'd0, 4'b1111, 32'hCAFEF00D, lat, o, e);
    req(0, 1'b1, 1'b0, 30'd1024, 4'b0000, 32'h0, lat, o, e);
    check("oor read error", {31'b0, e}, 32'd1);
    check("oor read data", o, 32'h0);
    req(0, 1'b0, 1'b1, 30'd1024, 4'b1111, 32'hFFFFFFFF, lat, o, e);
    check("oor write error", {31'b0, e}, 32'd1);
    req(0, 1'b1, 1'b0, 30'd0, 4'b0000, 32'h0, lat, o, e);
    check("addr0 intact", o, 32'hCAFEF00D);

    // Read and write together, then an empty-mask write.
    req(0, 1'b1, 1'b1, 30'd5, 4'b1111, 32'h0, lat, o, e);
    check("rw error", {31'b0, e}, 32'd1);
    check("rw data", o, 32'h0);
    req(0, 1'b1, 1'b0, 30'd5, 4'b0000, 32'h0, lat, o, e);
    check("r5 after rw", o, 32'hDEADBBAA);
    req(0, 1'b0, 1'b1, 30'd5, 4'b0000, 32'h11223344, lat, o, e);
    check("mask0 error", {31'b0, e}, 32'd0);
    req(0, 1'b1, 1'b0, 30'd5, 4'b0000, 32'h0, lat, o, e);
    check("r5 after mask0", o, 32'hDEADBBAA);

    // Reset in the cycle after accept discards the pending write.
    req(0, 1'b0, 1'b1, 30'd7, 4'b1111, 32'h11111111, lat, o, e);
    wr[0] = 1'b1; addr[0] = 30'd7; mask[0] = 4'b1111; wdata[0] = 32'h12345678;
    @(negedge clk);
    check("pre-reset accept ready", {31'b0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    wr[0] = 1'b0; rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("ready after reset", {31'b0, rdy[0]}, 32'd1);
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv[0]) rv_cnt++;
    end
    check("no resp after reset", 32'(rv_cnt), 32'd0);
    @(posedge clk); #1;
    req(0, 1'b1, 1'b0, 30'd7, 4'b0000, 32'h0, lat, o, e);
    check("r7 prior value", o, 32'h11111111);

    // Zero wait states: latency 1, held request accepted every other cycle.
    req(1, 1'b0, 1'b1, 30'd3, 4'b1111, 32'hA5A5A5A5, lat, o, e);
    check("w0 write latency", 32'(lat), 32'd1);
    req(1, 1'b1, 1'b0, 30'd3, 4'b0000, 32'h0, lat, o, e);
    check("w0 read latency", 32'(lat), 32'd1);
    check("w0 read data", o, 32'hA5A5A5A5);
    rd[1] = 1'b1; addr[1] = 30'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rv_pat[i]  = rv[1];
      rdy_pat[i] = rdy[1];
      @(posedge clk); #1;
    end
    rd[1] = 1'b0;
    check("held rv pattern", {26'b0, rv_pat}, 32'b101010);
    check("held ready pattern", {26'b0, rdy_pat}, 32'b010101);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
